// File: rtl/flit_channel_arbiter.sv
// flit_channel_arbiter: round-robin N:1 flit arbiter with zero-latency mux and backpressure hold.
// Define FLIT_ARB_PACKET_LOCK_EN to hold the grant from the head flit through the tail flit.
module flit_channel_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = 72
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_REQ-1:0]            in_flit_valid,
  output logic [NUM_REQ-1:0]            in_flit_ready,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          out_flit_valid,
  input  logic                          out_flit_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW:0] NUM_REQ_W = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  state_t        next_state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_reg;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] rr_next;
  logic [GW:0]   sel_sum;
  logic [NUM_REQ-1:0] valid_rot;
  logic          out_fire;
  logic          fire_tail;
  logic          load_grant;

  assign out_fire = out_flit_valid && out_flit_ready;

`ifdef FLIT_ARB_PACKET_LOCK_EN
  assign fire_tail = out_fire && out_flit[FLIT_WIDTH-2];
`else
  assign fire_tail = out_fire;
`endif

  // Rotate valids so bit 0 is rr_ptr; the lowest set bit (last write wins) is the winner.
  always_comb begin
    valid_rot = NUM_REQ'({in_flit_valid, in_flit_valid} >> rr_ptr);
    sel_idx   = rr_ptr;
    sel_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        sel_sum = {1'b0, rr_ptr} + (GW+1)'(k);
        if (sel_sum >= NUM_REQ_W) begin
          sel_sum = sel_sum - NUM_REQ_W;
        end
        sel_idx = sel_sum[GW-1:0];
      end
    end
    if (!RST_N) begin
      sel_idx = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_reg <= '0;
    end else begin
      state <= next_state;
      if (load_grant) begin
        grant_reg <= sel_idx;
      end
      if (fire_tail) begin
        rr_ptr <= rr_next;
      end
    end
  end

  // A presented flit that is not a completed tail pins the grant until it is.
  always_comb begin
    next_state = state;
    load_grant = 1'b0;
    rr_next    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    unique case (state)
      IDLE: begin
        if (out_flit_valid && !fire_tail) begin
          next_state = LOCK;
          load_grant = 1'b1;
        end
      end
      LOCK: begin
        if (fire_tail) begin
          next_state = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    busy           = (state == LOCK);
    grant_id       = (state == LOCK) ? grant_reg : sel_idx;
    out_flit       = '0;
    out_flit_valid = 1'b0;
    in_flit_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        out_flit         = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        out_flit_valid   = in_flit_valid[i];
        in_flit_ready[i] = out_flit_ready;
      end
    end
  end

endmodule

// File: tb/tb_flit_channel_arbiter.sv
// tb_flit_channel_arbiter: scoreboard bench; per-requester flit sources, expected fires queued in order.
// Expectations track whether FLIT_ARB_PACKET_LOCK_EN is defined for the build.
module tb_flit_channel_arbiter;

  localparam int NREQ  = 4;
  localparam int FW    = 72;
  localparam int GW    = 2;
  localparam int DEPTH = 16;

  logic             CLK;
  logic             RST_N;
  logic [NREQ*FW-1:0] in_flit;
  logic [NREQ-1:0]  in_flit_valid;
  logic [NREQ-1:0]  in_flit_ready;
  logic [FW-1:0]    out_flit;
  logic             out_flit_valid;
  logic             out_flit_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;

  logic [FW-1:0] src_mem [NREQ][DEPTH];
  int            src_rd  [NREQ];
  int            src_wr  [NREQ];
  int            exp_ptr [NREQ];
  logic [NREQ-1:0] hold;

  int            exp_req  [$];
  logic [FW-1:0] exp_flit [$];
  logic          exp_busy [$];

  int            vectors;
  int            miscompares;
  int            fire_count;
  int            cycles;
  bit            lock_mode;
  logic [FW-1:0] last_flit;
  logic [FW-1:0] z_flit;

  flit_channel_arbiter #(.NUM_REQ(NREQ), .FLIT_WIDTH(FW)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .in_flit        (in_flit),
    .in_flit_valid  (in_flit_valid),
    .in_flit_ready  (in_flit_ready),
    .out_flit       (out_flit),
    .out_flit_valid (out_flit_valid),
    .out_flit_ready (out_flit_ready),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [FW-1:0] observed, input logic [FW-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Flit carries requester and sequence in its low bytes so a wrong grant shows in the data.
  task automatic applyStimulus(input int req, input bit tail);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1]    = 1'b1;
    f[FW-2]    = tail;
    f[47:16]   = $urandom;
    f[15:8]    = 8'(req);
    f[7:0]     = 8'(src_wr[req]);
    src_mem[req][src_wr[req]] = f;
    src_wr[req] = src_wr[req] + 1;
    last_flit = f;
  endtask

  task automatic expectFire(input int req, input bit b);
    exp_req.push_back(req);
    exp_flit.push_back(src_mem[req][exp_ptr[req]]);
    exp_busy.push_back(b);
    exp_ptr[req] = exp_ptr[req] + 1;
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_rd[i] < src_wr[i] && !hold[i]) begin
        in_flit_valid[i]    = 1'b1;
        in_flit[i*FW +: FW] = src_mem[i][src_rd[i]];
      end else begin
        in_flit_valid[i]    = 1'b0;
        in_flit[i*FW +: FW] = '0;
      end
    end
  endtask

  // Sample at the falling edge; a fire pops the scoreboard and the expected requester's source.
  task automatic stepCycle();
    int            r;
    logic [FW-1:0] f;
    logic          b;
    bit            fired;
    fired = 1'b0;
    r     = 0;
    @(negedge CLK);
    if (out_flit_valid && out_flit_ready) begin
      if (exp_req.size() == 0) begin
        checkOutput("unexpected_fire", FW'(grant_id), '1);
      end else begin
        r = exp_req.pop_front();
        f = exp_flit.pop_front();
        b = exp_busy.pop_front();
        checkOutput("fire_grant", FW'(grant_id), FW'(r));
        checkOutput("fire_flit", out_flit, f);
        checkOutput("fire_busy", FW'(busy), FW'(b));
        checkOutput("fire_ready", FW'(in_flit_ready), FW'(1) << r);
        fired = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    if (fired) begin
      src_rd[r]  = src_rd[r] + 1;
      fire_count = fire_count + 1;
    end
    driveInputs();
  endtask

  task automatic flushAll();
    exp_req.delete();
    exp_flit.delete();
    exp_busy.delete();
    for (int i = 0; i < NREQ; i++) begin
      src_rd[i]  = src_wr[i];
      exp_ptr[i] = src_wr[i];
    end
    driveInputs();
  endtask

  task automatic runUntilDrained(input int budget, output int used);
    used = 0;
    while (exp_req.size() > 0 && used < budget) begin
      stepCycle();
      used++;
    end
    if (exp_req.size() > 0) begin
      checkOutput("drain_timeout", FW'(exp_req.size()), '0);
      flushAll();
    end
  endtask

  task automatic runFires(input int n, input int budget);
    int target;
    int used;
    target = fire_count + n;
    used   = 0;
    while (fire_count < target && used < budget) begin
      stepCycle();
      used++;
    end
    if (fire_count < target) begin
      checkOutput("fire_timeout", FW'(target - fire_count), '0);
      flushAll();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fire_count  = 0;
    lock_mode   = 1'b0;
`ifdef FLIT_ARB_PACKET_LOCK_EN
    lock_mode   = 1'b1;
`endif
    for (int i = 0; i < NREQ; i++) begin
      src_rd[i]  = 0;
      src_wr[i]  = 0;
      exp_ptr[i] = 0;
    end
    hold           = '0;
    in_flit        = '0;
    in_flit_valid  = '0;
    out_flit_ready = 1'b0;
    RST_N          = 1'b0;

    // Reset: grant pinned to 0, valid follows requester 0.
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b1);
    applyStimulus(2, 1'b1);
    applyStimulus(2, 1'b1);
    driveInputs();
    @(negedge CLK);
    checkOutput("rst_busy", FW'(busy), '0);
    checkOutput("rst_grant", FW'(grant_id), '0);
    checkOutput("rst_valid", FW'(out_flit_valid), FW'(1));
    checkOutput("rst_flit", out_flit, src_mem[0][0]);
    hold[0] = 1'b1;
    driveInputs();
    #1;
    checkOutput("rst_valid_req0_low", FW'(out_flit_valid), '0);
    checkOutput("rst_grant_req0_low", FW'(grant_id), '0);
    hold[0] = 1'b0;
    @(posedge CLK);
    #1;
    RST_N          = 1'b1;
    out_flit_ready = 1'b1;
    driveInputs();

    // Single-flit round robin over requesters 0 and 2.
    expectFire(0, 1'b0);
    expectFire(2, 1'b0);
    expectFire(0, 1'b0);
    expectFire(2, 1'b0);
    runUntilDrained(20, cycles);
    checkOutput("rr_back_to_back_cycles", FW'(cycles), FW'(4));

    // Requester 1 sends a 3-flit packet while requester 3 stays valid.
    applyStimulus(3, 1'b1);
    applyStimulus(3, 1'b1);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b1);
    driveInputs();
    if (lock_mode) begin
      expectFire(3, 1'b0);
      expectFire(1, 1'b0);
      expectFire(1, 1'b1);
      expectFire(1, 1'b1);
      expectFire(3, 1'b0);
    end else begin
      expectFire(3, 1'b0);
      expectFire(1, 1'b0);
      expectFire(3, 1'b0);
      expectFire(1, 1'b0);
      expectFire(1, 1'b0);
    end
    runUntilDrained(30, cycles);

    // Two 2-flit packets on requesters 0 and 1.
    applyStimulus(0, 1'b0);
    applyStimulus(0, 1'b1);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b1);
    driveInputs();
    if (lock_mode) begin
      expectFire(0, 1'b0);
      expectFire(0, 1'b1);
      expectFire(1, 1'b0);
      expectFire(1, 1'b1);
    end else begin
      expectFire(0, 1'b0);
      expectFire(1, 1'b0);
      expectFire(0, 1'b0);
      expectFire(1, 1'b0);
    end
    runUntilDrained(30, cycles);

    // Backpressure: requester 2's flit must stay presented even after requester 0 joins.
    out_flit_ready = 1'b0;
    applyStimulus(2, 1'b1);
    z_flit = last_flit;
    driveInputs();
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        applyStimulus(0, 1'b1);
        driveInputs();
      end
      #1;
      checkOutput("bp_grant", FW'(grant_id), FW'(2));
      checkOutput("bp_flit", out_flit, z_flit);
      checkOutput("bp_valid", FW'(out_flit_valid), FW'(1));
      checkOutput("bp_busy", FW'(busy), FW'(c != 0));
      @(posedge CLK);
      #1;
    end
    out_flit_ready = 1'b1;
    expectFire(2, 1'b1);
    expectFire(0, 1'b0);
    runUntilDrained(20, cycles);

    // Requester 3 drops valid mid-packet while requester 0 waits.
    applyStimulus(3, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(3, 1'b1);
    applyStimulus(0, 1'b1);
    driveInputs();
    if (lock_mode) begin
      expectFire(3, 1'b0);
      expectFire(3, 1'b1);
      expectFire(3, 1'b1);
      expectFire(0, 1'b0);
    end else begin
      expectFire(3, 1'b0);
      expectFire(0, 1'b0);
      expectFire(3, 1'b0);
      expectFire(3, 1'b0);
    end
    runFires(1, 20);
    hold[3] = 1'b1;
    driveInputs();
    for (int c = 0; c < 2; c++) begin
      if (lock_mode) begin
        #1;
        checkOutput("drop_valid", FW'(out_flit_valid), '0);
        checkOutput("drop_grant", FW'(grant_id), FW'(3));
        checkOutput("drop_busy", FW'(busy), FW'(1));
      end
      stepCycle();
    end
    hold[3] = 1'b0;
    driveInputs();
    runUntilDrained(20, cycles);

    // Reset pulsed mid-packet on requester 2; arbitration restarts from requester 0.
    applyStimulus(2, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(2, 1'b1);
    driveInputs();
    expectFire(2, 1'b0);
    runFires(1, 20);
    applyStimulus(1, 1'b1);
    out_flit_ready = 1'b0;
    RST_N          = 1'b0;
    driveInputs();
    #1;
    checkOutput("midrst_busy", FW'(busy), '0);
    checkOutput("midrst_grant", FW'(grant_id), '0);
    checkOutput("midrst_valid", FW'(out_flit_valid), '0);
    @(posedge CLK);
    #1;
    RST_N          = 1'b1;
    out_flit_ready = 1'b1;
    #1;
    checkOutput("postrst_busy", FW'(busy), '0);
    checkOutput("postrst_grant", FW'(grant_id), FW'(1));
    expectFire(1, 1'b0);
    expectFire(2, 1'b0);
    expectFire(2, lock_mode);
    runUntilDrained(20, cycles);

    repeat (2) stepCycle();
    checkOutput("end_idle_busy", FW'(busy), '0);
    checkOutput("end_idle_valid", FW'(out_flit_valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flit_channel_arbiter.md
FLIT_CHANNEL_ARBITER -- requirements
Module: flit_channel_arbiter

Interface
REQ-001 The block SHALL expose parameter NUM_REQ, default 4, giving the number of flit requesters sharing one downstream serializer/link port (range 2..16).
REQ-002 The block SHALL expose parameter FLIT_WIDTH, default 72, giving the width of each flit in {valid, tail, dest, vc, data} format, MSB first.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock.
REQ-004 The block SHALL have port RST_N, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port in_flit, input, NUM_REQ*FLIT_WIDTH bits; requester i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-006 The block SHALL have port in_flit_valid, input, NUM_REQ bits, one valid bit per requester.
REQ-007 The block SHALL have port in_flit_ready, output, NUM_REQ bits, one ready bit per requester.
REQ-008 The block SHALL have port out_flit, output, FLIT_WIDTH bits, the granted flit.
REQ-009 The block SHALL have port out_flit_valid, output, 1 bit.
REQ-010 The block SHALL have port out_flit_ready, input, 1 bit.
REQ-011 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits, the index currently driving out_flit.
REQ-012 The block SHALL have port busy, output, 1 bit, high while in state LOCK.

Function
REQ-013 The tail bit SHALL be in_flit bit FLIT_WIDTH-2 of the granted requester; out_fire SHALL be defined as out_flit_valid && out_flit_ready.
REQ-014 The block SHALL implement two states: IDLE and LOCK.
REQ-015 In IDLE, the block SHALL combinationally select the first requester with valid set, searching from rr_ptr upward modulo NUM_REQ; grant_id SHALL equal that selection, and SHALL equal rr_ptr when no requester is valid.
REQ-016 In LOCK, grant_id SHALL equal the registered grant_reg, and no other requester SHALL be selected.
REQ-017 out_flit SHALL equal the granted requester's flit and out_flit_valid SHALL equal that requester's valid bit; the path SHALL have zero added latency and no flit storage.
REQ-018 in_flit_ready[i] SHALL equal out_flit_ready when i == grant_id, and 0 otherwise; out_flit_valid SHALL NOT depend on out_flit_ready.
REQ-019 In IDLE, when out_flit_valid && !out_flit_ready, the block SHALL move to LOCK with grant_reg set to the selection, so the presented flit stays stable until accepted.
REQ-020 In IDLE, on out_fire of a non-tail flit, the block SHALL move to LOCK with grant_reg set to the selection; on out_fire of a tail flit, it SHALL stay in IDLE.
REQ-021 In LOCK, on out_fire of a tail flit, the block SHALL return to IDLE; otherwise it SHALL remain in LOCK.
REQ-022 If the granted requester drops valid mid-packet while in LOCK, the block SHALL stay in LOCK with out_flit_valid=0 and SHALL NOT switch requesters.
REQ-023 On every out_fire of a tail flit, rr_ptr SHALL load (grant_id+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-024 Each fire SHALL involve exactly one requester; no flit SHALL be dropped or duplicated.

Reset
REQ-025 While RST_N=0, the block SHALL set state=IDLE, rr_ptr=0 and grant_reg=0, giving busy=0 and grant_id=0; out_flit_valid SHALL follow in_flit_valid[0].
REQ-026 Reset asserted mid-packet SHALL abandon the lock immediately; after reset, arbitration SHALL restart from requester 0.

Configuration
REQ-027 With macro FLIT_ARB_PACKET_LOCK_EN defined, grant SHALL be held from the first flit through the tail flit, as in REQ-020 and REQ-021.
REQ-028 Without FLIT_ARB_PACKET_LOCK_EN, every out_fire SHALL be treated as a tail, so arbitration is per flit; LOCK SHALL be entered only for backpressure per REQ-019.

Verification
REQ-029 Reset, then valid=4'b0101, ready=1, all single-flit packets: grants SHALL be 0,2,0,2 on consecutive cycles.
REQ-030 With FLIT_ARB_PACKET_LOCK_EN, requester 1 sends a 3-flit packet (tail on flit 3) while requester 3 stays valid: grant_id SHALL be 1 for 3 fires, then 3; busy SHALL be high for cycles 1-2 after the first fire.
REQ-031 Requester 2 valid, out_flit_ready=0 for 5 cycles, then requester 0 also asserts valid: out_flit and grant_id=2 SHALL hold stable until ready rises.
REQ-032 Mid-packet on requester 3, valid drops for 2 cycles while requester 0 is valid: out_flit_valid SHALL be 0, grant_id SHALL stay 3, and the packet SHALL resume on requester 3.
REQ-033 RST_N pulsed low mid-packet on requester 2: after release, busy SHALL be 0 and the next grant SHALL be the lowest valid index searched from 0.
REQ-034 Without FLIT_ARB_PACKET_LOCK_EN, requesters 0 and 1 each send 2-flit packets: fires SHALL alternate grant 0,1,0,1.
